// File: rtl/fpu_issue_if.sv
// Issue handshake between core decode and the FP issue controller.
// Decode drives the op and register fields; the controller answers with ready.
interface fpu_issue_if;
  logic       issue_valid;
  logic       issue_ready;
  logic [2:0] issue_op;
  logic [4:0] issue_fd;
  logic [4:0] issue_fs;
  logic [4:0] issue_ft;

  modport master (
    output issue_valid, issue_op, issue_fd, issue_fs, issue_ft,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_op, issue_fd, issue_fs, issue_ft,
    output issue_ready
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FP issue/writeback sequencer: hazard interlock, unit launch and fixed-latency
// writeback through a reservation shift register.
module fpu_issue_ctrl #(
  parameter int LAT_ADD = 2,
  parameter int LAT_MUL = 3,
  parameter int LAT_DIV = 12,
  parameter int MAXLAT  = 16
) (
  input  logic        CLK,
  input  logic        RST,
  fpu_issue_if.slave  iss,
  output logic [4:0]  rd_fs_addr,
  output logic [4:0]  rd_ft_addr,
  input  logic [31:0] rd_fs_data,
  input  logic [31:0] rd_ft_data,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        add_start,
  output logic        add_sub,
  output logic        mul_start,
  output logic        div_start,
  input  logic [31:0] add_result,
  input  logic [31:0] mul_result,
  input  logic [31:0] div_result,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        busy
);

  localparam int IW = $clog2(MAXLAT);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOV = 3'd4;

  localparam logic [1:0] U_ADD = 2'd0;
  localparam logic [1:0] U_MUL = 2'd1;
  localparam logic [1:0] U_DIV = 2'd2;
  localparam logic [1:0] U_MOV = 2'd3;

  logic [MAXLAT-1:0] slot_v;
  logic [1:0]        slot_u  [MAXLAT];
  logic [4:0]        slot_fd [MAXLAT];
  logic [31:0]       pending;
  logic [31:0]       mov_q;

  logic          is_add, is_mul, is_div, is_mov, is_nop, uses_ft;
  logic [IW-1:0] lat, lat_m1;
  logic [1:0]    unit;
  logic          div_inflight;
  logic          hazard, fire, launch;
  logic [31:0]   set_mask, clr_mask;

  always_comb begin
    is_add  = (iss.issue_op == OP_ADD) || (iss.issue_op == OP_SUB);
    is_mul  = (iss.issue_op == OP_MUL);
    is_div  = (iss.issue_op == OP_DIV);
    is_mov  = (iss.issue_op == OP_MOV);
    is_nop  = (iss.issue_op > OP_MOV);
    uses_ft = is_add || is_mul || is_div;
    lat     = IW'(1);
    unit    = U_MOV;
    if (is_add) begin
      lat  = IW'(LAT_ADD);
      unit = U_ADD;
    end else if (is_mul) begin
      lat  = IW'(LAT_MUL);
      unit = U_MUL;
    end else if (is_div) begin
      lat  = IW'(LAT_DIV);
      unit = U_DIV;
    end
    lat_m1 = lat - IW'(1);
  end

  // Div unit is not pipelined: any div still in the reservation register blocks a new one.
  always_comb begin
    div_inflight = 1'b0;
    for (int i = 0; i < MAXLAT; i++) begin
      if (slot_v[i] && slot_u[i] == U_DIV) div_inflight = 1'b1;
    end
  end

  always_comb begin
    hazard = pending[iss.issue_fs]
          || (uses_ft && pending[iss.issue_ft])
          || pending[iss.issue_fd]
          || slot_v[lat]
          || (is_div && div_inflight);
    iss.issue_ready = !RST && (is_nop || !hazard);
    fire   = iss.issue_valid && iss.issue_ready;
    launch = fire && !is_nop;
  end

  assign rd_fs_addr = iss.issue_fs;
  assign rd_ft_addr = iss.issue_ft;
  assign op_a       = rd_fs_data;
  assign op_b       = rd_ft_data;
  assign add_start  = fire && is_add;
  assign add_sub    = is_add && (iss.issue_op == OP_SUB);
  assign mul_start  = fire && is_mul;
  assign div_start  = fire && is_div;

  always_comb begin
    wb_en   = slot_v[0];
    wb_addr = slot_v[0] ? slot_fd[0] : 5'd0;
    wb_data = 32'd0;
    if (slot_v[0]) begin
      case (slot_u[0])
        U_ADD:   wb_data = add_result;
        U_MUL:   wb_data = mul_result;
        U_DIV:   wb_data = div_result;
        default: wb_data = mov_q;
      endcase
    end
  end

  assign busy     = |pending;
  assign set_mask = launch ? (32'd1 << iss.issue_fd) : 32'd0;
  assign clr_mask = wb_en ? (32'd1 << wb_addr) : 32'd0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      slot_v  <= '0;
      pending <= '0;
      mov_q   <= '0;
      for (int i = 0; i < MAXLAT; i++) begin
        slot_u[i]  <= U_ADD;
        slot_fd[i] <= 5'd0;
      end
    end else begin
      for (int i = 0; i < MAXLAT - 1; i++) begin
        slot_v[i]  <= slot_v[i+1];
        slot_u[i]  <= slot_u[i+1];
        slot_fd[i] <= slot_fd[i+1];
      end
      slot_v[MAXLAT-1]  <= 1'b0;
      slot_u[MAXLAT-1]  <= U_ADD;
      slot_fd[MAXLAT-1] <= 5'd0;
      // Entry lands at L-1 after this shift so it reaches slot 0 exactly L cycles after fire.
      if (launch) begin
        slot_v[lat_m1]  <= 1'b1;
        slot_u[lat_m1]  <= unit;
        slot_fd[lat_m1] <= iss.issue_fd;
      end
      pending <= (pending & ~clr_mask) | set_mask;
      if (fire && is_mov) mov_q <= rd_fs_data;
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: hazards, port conflicts, div occupancy,
// MOV/NOP handling and reset flush, with hand-computed expectations.
module tb_fpu_issue_ctrl;
  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  rd_fs_addr, rd_ft_addr;
  logic [31:0] rd_fs_data, rd_ft_data;
  logic [31:0] op_a, op_b;
  logic        add_start, add_sub, mul_start, div_start;
  logic [31:0] add_result, mul_result, div_result;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        busy;
  logic [31:0] rf [32];

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] ADD_R = 32'h4040_0000;
  localparam logic [31:0] MUL_R = 32'h1111_1111;
  localparam logic [31:0] DIV_R = 32'h2222_2222;

  fpu_issue_if ifc ();

  fpu_issue_ctrl dut (
    .CLK(CLK), .RST(RST), .iss(ifc),
    .rd_fs_addr(rd_fs_addr), .rd_ft_addr(rd_ft_addr),
    .rd_fs_data(rd_fs_data), .rd_ft_data(rd_ft_data),
    .op_a(op_a), .op_b(op_b),
    .add_start(add_start), .add_sub(add_sub), .mul_start(mul_start), .div_start(div_start),
    .add_result(add_result), .mul_result(mul_result), .div_result(div_result),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy)
  );

  always #5 CLK = ~CLK;

  assign rd_fs_data = rf[rd_fs_addr];
  assign rd_ft_data = rf[rd_ft_addr];

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [4:0] fd,
                       input logic [4:0] fs, input logic [4:0] ft);
    ifc.issue_valid = v;
    ifc.issue_op    = op;
    ifc.issue_fd    = fd;
    ifc.issue_fs    = fs;
    ifc.issue_ft    = ft;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive(1'b1, 3'd0, 5'd0, 5'd0, 5'd0);
    @(negedge CLK);
    total++; if (ifc.issue_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", ifc.issue_ready); end
    total++; if (add_start !== 1'b0) begin bad++; $display("FAIL rst_add_start got=%b exp=0", add_start); end
    adv(); adv();
    RST = 1'b0;
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
    @(negedge CLK);
    total++; if (ifc.issue_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b exp=1", ifc.issue_ready); end
    total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL post_rst_wb_en got=%b exp=0", wb_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy got=%b exp=0", busy); end
    adv();
  endtask

  task automatic test_add();
    drive(1'b1, 3'd0, 5'd3, 5'd1, 5'd2);
    @(negedge CLK);
    total++; if (add_start !== 1'b1 || add_sub !== 1'b0) begin bad++; $display("FAIL add_start got=%b/%b exp=1/0", add_start, add_sub); end
    total++; if (op_a !== 32'h3F80_0000 || op_b !== 32'h4000_0000) begin bad++; $display("FAIL add_operands got=%h/%h exp=3f800000/40000000", op_a, op_b); end
    adv();
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
    @(negedge CLK);
    total++; if (wb_en !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL add_c1 wb_en/busy got=%b/%b exp=0/1", wb_en, busy); end
    adv();
    @(negedge CLK);
    total++; if (wb_en !== 1'b1 || wb_addr !== 5'd3 || wb_data !== 32'h4040_0000) begin bad++; $display("FAIL add_wb got=%b/%0d/%h exp=1/3/40400000", wb_en, wb_addr, wb_data); end
    adv();
    @(negedge CLK);
    total++; if (wb_en !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL add_c3 wb_en/busy got=%b/%b exp=0/0", wb_en, busy); end
  endtask

  task automatic test_raw();
    adv();
    drive(1'b1, 3'd2, 5'd4, 5'd1, 5'd2);
    @(negedge CLK);
    total++; if (mul_start !== 1'b1) begin bad++; $display("FAIL raw_mul_start got=%b exp=1", mul_start); end
    adv();
    drive(1'b1, 3'd0, 5'd5, 5'd4, 5'd1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK);
      total++; if (ifc.issue_ready !== 1'b0 || add_start !== 1'b0) begin bad++; $display("FAIL raw_stall c%0d ready/start got=%b/%b exp=0/0", c, ifc.issue_ready, add_start); end
      if (c == 3) begin
        total++; if (wb_en !== 1'b1 || wb_addr !== 5'd4 || wb_data !== MUL_R) begin bad++; $display("FAIL raw_mul_wb got=%b/%0d/%h exp=1/4/%h", wb_en, wb_addr, wb_data, MUL_R); end
      end
      adv();
    end
    @(negedge CLK);
    total++; if (ifc.issue_ready !== 1'b1 || add_start !== 1'b1) begin bad++; $display("FAIL raw_fire c4 ready/start got=%b/%b exp=1/1", ifc.issue_ready, add_start); end
    adv();
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
    adv();
    @(negedge CLK);
    total++; if (wb_en !== 1'b1 || wb_addr !== 5'd5 || wb_data !== ADD_R) begin bad++; $display("FAIL raw_add_wb got=%b/%0d/%h exp=1/5/%h", wb_en, wb_addr, wb_data, ADD_R); end
    adv();
  endtask

  task automatic test_port_conflict();
    drive(1'b1, 3'd2, 5'd4, 5'd1, 5'd2);
    adv();
    drive(1'b1, 3'd0, 5'd5, 5'd1, 5'd2);
    @(negedge CLK);
    total++; if (ifc.issue_ready !== 1'b0) begin bad++; $display("FAIL port_stall ready got=%b exp=0", ifc.issue_ready); end
    adv();
    @(negedge CLK);
    total++; if (ifc.issue_ready !== 1'b1 || add_start !== 1'b1) begin bad++; $display("FAIL port_fire ready/start got=%b/%b exp=1/1", ifc.issue_ready, add_start); end
    adv();
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
    @(negedge CLK);
    total++; if (wb_en !== 1'b1 || wb_addr !== 5'd4 || wb_data !== MUL_R) begin bad++; $display("FAIL port_mul_wb got=%b/%0d/%h exp=1/4/%h", wb_en, wb_addr, wb_data, MUL_R); end
    adv();
    @(negedge CLK);
    total++; if (wb_en !== 1'b1 || wb_addr !== 5'd5 || wb_data !== ADD_R) begin bad++; $display("FAIL port_add_wb got=%b/%0d/%h exp=1/5/%h", wb_en, wb_addr, wb_data, ADD_R); end
    adv();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 3'd1, 5'd12, 5'd1, 5'd2);
    @(negedge CLK);
    total++; if (add_start !== 1'b1 || add_sub !== 1'b1) begin bad++; $display("FAIL b2b_sub start/sub got=%b/%b exp=1/1", add_start, add_sub); end
    adv();
    drive(1'b1, 3'd0, 5'd13, 5'd1, 5'd2);
    @(negedge CLK);
    total++; if (ifc.issue_ready !== 1'b1 || add_start !== 1'b1) begin bad++; $display("FAIL b2b_second ready/start got=%b/%b exp=1/1", ifc.issue_ready, add_start); end
    adv();
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
    @(negedge CLK);
    total++; if (wb_en !== 1'b1 || wb_addr !== 5'd12) begin bad++; $display("FAIL b2b_wb12 got=%b/%0d exp=1/12", wb_en, wb_addr); end
    adv();
    @(negedge CLK);
    total++; if (wb_en !== 1'b1 || wb_addr !== 5'd13) begin bad++; $display("FAIL b2b_wb13 got=%b/%0d exp=1/13", wb_en, wb_addr); end
    adv();
    @(negedge CLK);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle busy got=%b exp=0", busy); end
    adv();
  endtask

  task automatic test_div_add();
    drive(1'b1, 3'd3, 5'd6, 5'd1, 5'd2);
    @(negedge CLK);
    total++; if (div_start !== 1'b1) begin bad++; $display("FAIL divadd_div_start got=%b exp=1", div_start); end
    adv();
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
    for (int c = 1; c <= 9; c++) adv();
    drive(1'b1, 3'd0, 5'd7, 5'd1, 5'd2);
    @(negedge CLK);
    total++; if (ifc.issue_ready !== 1'b0) begin bad++; $display("FAIL divadd_c10 ready got=%b exp=0", ifc.issue_ready); end
    adv();
    @(negedge CLK);
    total++; if (ifc.issue_ready !== 1'b1 || add_start !== 1'b1) begin bad++; $display("FAIL divadd_c11 ready/start got=%b/%b exp=1/1", ifc.issue_ready, add_start); end
    adv();
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
    @(negedge CLK);
    total++; if (wb_en !== 1'b1 || wb_addr !== 5'd6 || wb_data !== DIV_R) begin bad++; $display("FAIL divadd_wb6 got=%b/%0d/%h exp=1/6/%h", wb_en, wb_addr, wb_data, DIV_R); end
    adv();
    @(negedge CLK);
    total++; if (wb_en !== 1'b1 || wb_addr !== 5'd7 || wb_data !== ADD_R) begin bad++; $display("FAIL divadd_wb7 got=%b/%0d/%h exp=1/7/%h", wb_en, wb_addr, wb_data, ADD_R); end
    adv();
  endtask

  task automatic test_div_div();
    drive(1'b1, 3'd3, 5'd1, 5'd2, 5'd3);
    @(negedge CLK);
    total++; if (div_start !== 1'b1) begin bad++; $display("FAIL divdiv_first start got=%b exp=1", div_start); end
    adv();
    drive(1'b1, 3'd3, 5'd2, 5'd3, 5'd4);
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      total++; if (ifc.issue_ready !== 1'b0 || div_start !== 1'b0) begin bad++; $display("FAIL divdiv_stall c%0d ready/start got=%b/%b exp=0/0", c, ifc.issue_ready, div_start); end
      if (c == 12) begin
        total++; if (wb_en !== 1'b1 || wb_addr !== 5'd1) begin bad++; $display("FAIL divdiv_wb1 got=%b/%0d exp=1/1", wb_en, wb_addr); end
      end
      adv();
    end
    @(negedge CLK);
    total++; if (ifc.issue_ready !== 1'b1 || div_start !== 1'b1) begin bad++; $display("FAIL divdiv_c13 ready/start got=%b/%b exp=1/1", ifc.issue_ready, div_start); end
    adv();
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
    for (int c = 14; c <= 25; c++) begin
      @(negedge CLK);
      total++; if (wb_en !== (c == 25)) begin bad++; $display("FAIL divdiv_wb c%0d wb_en got=%b exp=%b", c, wb_en, (c == 25)); end
      if (c == 25) begin
        total++; if (wb_addr !== 5'd2 || wb_data !== DIV_R) begin bad++; $display("FAIL divdiv_wb2 got=%0d/%h exp=2/%h", wb_addr, wb_data, DIV_R); end
      end
      adv();
    end
  endtask

  task automatic test_mov_nop();
    drive(1'b1, 3'd0, 5'd10, 5'd1, 5'd2);
    adv();
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
    adv();
    drive(1'b1, 3'd4, 5'd9, 5'd8, 5'd10);
    @(negedge CLK);
    total++; if (ifc.issue_ready !== 1'b1 || add_start !== 1'b0 || mul_start !== 1'b0 || div_start !== 1'b0) begin bad++; $display("FAIL mov_fire ready/a/m/d got=%b/%b/%b/%b exp=1/0/0/0", ifc.issue_ready, add_start, mul_start, div_start); end
    total++; if (wb_en !== 1'b1 || wb_addr !== 5'd10) begin bad++; $display("FAIL mov_add_wb got=%b/%0d exp=1/10", wb_en, wb_addr); end
    adv();
    drive(1'b1, 3'd5, 5'd9, 5'd9, 5'd9);
    @(negedge CLK);
    total++; if (wb_en !== 1'b1 || wb_addr !== 5'd9 || wb_data !== 32'h1234_5678) begin bad++; $display("FAIL mov_wb got=%b/%0d/%h exp=1/9/12345678", wb_en, wb_addr, wb_data); end
    total++; if (ifc.issue_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL nop_hazard ready/busy got=%b/%b exp=1/1", ifc.issue_ready, busy); end
    adv();
    drive(1'b1, 3'd7, 5'd9, 5'd9, 5'd9);
    @(negedge CLK);
    total++; if (ifc.issue_ready !== 1'b1 || wb_en !== 1'b0 || busy !== 1'b0 || add_start !== 1'b0) begin bad++; $display("FAIL nop_idle ready/wb/busy/start got=%b/%b/%b/%b exp=1/0/0/0", ifc.issue_ready, wb_en, busy, add_start); end
    adv();
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
    @(negedge CLK);
    total++; if (wb_en !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL nop_after wb/busy got=%b/%b exp=0/0", wb_en, busy); end
    adv();
  endtask

  task automatic test_reset_flush();
    drive(1'b1, 3'd2, 5'd4, 5'd1, 5'd2);
    @(negedge CLK);
    total++; if (mul_start !== 1'b1) begin bad++; $display("FAIL flush_mul_start got=%b exp=1", mul_start); end
    adv();
    RST = 1'b1;
    drive(1'b1, 3'd0, 5'd11, 5'd1, 5'd2);
    @(negedge CLK);
    total++; if (ifc.issue_ready !== 1'b0 || add_start !== 1'b0) begin bad++; $display("FAIL flush_c1 ready/start got=%b/%b exp=0/0", ifc.issue_ready, add_start); end
    adv();
    RST = 1'b0;
    drive(1'b0, 3'd0, 5'd11, 5'd1, 5'd2);
    @(negedge CLK);
    total++; if (busy !== 1'b0 || wb_en !== 1'b0 || ifc.issue_ready !== 1'b1) begin bad++; $display("FAIL flush_c2 busy/wb/ready got=%b/%b/%b exp=0/0/1", busy, wb_en, ifc.issue_ready); end
    adv();
    @(negedge CLK);
    total++; if (wb_en !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL flush_c3 wb/busy got=%b/%b exp=0/0", wb_en, busy); end
    adv();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
    rf[1] = 32'h3F80_0000;
    rf[2] = 32'h4000_0000;
    rf[8] = 32'h1234_5678;
    add_result = ADD_R;
    mul_result = MUL_R;
    div_result = DIV_R;
    RST = 1'b1;
    drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0);
    #1;
    test_reset();
    test_add();
    test_raw();
    test_port_conflict();
    test_back_to_back();
    test_div_add();
    test_div_div();
    test_mov_nop();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
